// File: rtl/cap_sensor_scanner.sv
// Scans NUM_SENSORS capacitive pads by timing each pad's charge against a shared drive, then debounces the result.
// Latency: one scan is DISCHARGE_CYCLES + (last capture + 1) + 1 clocks; touched updates at the end of EVAL, press_pending one clock later.
// No backpressure: scanning free-runs while enable is high; press_pending holds events until software clears them via clear_mask.
module cap_sensor_scanner #(
    parameter int NUM_SENSORS      = 9,
    parameter int CNT_WIDTH        = 16,
    parameter int THRESHOLD        = 50,
    parameter int DISCHARGE_CYCLES = 8,
    parameter int TIMEOUT          = 255,
    parameter int DEBOUNCE_SCANS   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
    output logic                   capacitive_sensors_out,
    output logic [NUM_SENSORS-1:0] touched,
    output logic [NUM_SENSORS-1:0] press_pending,
    input  logic [NUM_SENSORS-1:0] clear_mask,
    output logic                   scan_done,
    output logic                   busy
);

    // Counter widths sized so the terminal values always fit.
    localparam int DIS_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C   = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] THRESHOLD_C = CNT_WIDTH'(THRESHOLD);
    localparam logic [DIS_W-1:0]     DIS_LAST_C  = DIS_W'(DISCHARGE_CYCLES - 1);
    localparam logic [DB_W-1:0]      DB_LAST_C   = DB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISCHARGE,
        S_CHARGE,
        S_EVAL
    } state_e;

    // Scan FSM state and registered outputs.
    state_e                 state_q;
    logic [DIS_W-1:0]       dis_cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   drive_q;
    logic                   done_q;
    logic                   busy_q;

    // Per-channel capture of the charge time.
    logic [CNT_WIDTH-1:0]   cap_q [NUM_SENSORS];
    logic [CNT_WIDTH-1:0]   cap_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] valid_q;
    logic [NUM_SENSORS-1:0] hit_d;
    logic [NUM_SENSORS-1:0] valid_d;
    logic                   charge_exit_d;

    // Sense-pin synchronizer.
    logic [NUM_SENSORS-1:0] sync1_q;
    logic [NUM_SENSORS-1:0] sync2_q;

    // Debounce and press-event state.
    logic [NUM_SENSORS-1:0] raw_d;
    logic [DB_W-1:0]        db_cnt_q [NUM_SENSORS];
    logic [DB_W-1:0]        db_cnt_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] touched_q;
    logic [NUM_SENSORS-1:0] touched_d;
    logic [NUM_SENSORS-1:0] touched_prev_q;
    logic [NUM_SENSORS-1:0] press_q;
    logic [NUM_SENSORS-1:0] press_d;

    // Two-flop synchronizer on the raw sense pins; its lag is part of every capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= capacitive_sensors_in;
            sync2_q <= sync1_q;
        end
    end

    // Capture the current count for channels seeing their first high this cycle;
    // on leaving CHARGE any channel that never went high is pinned to TIMEOUT.
    always_comb begin
        hit_d = valid_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            cap_d[i] = cap_q[i];
            if (sync2_q[i] && !valid_q[i]) begin
                hit_d[i] = 1'b1;
                cap_d[i] = cnt_q;
            end
        end
        charge_exit_d = (&hit_d) || (cnt_q == TIMEOUT_C);
        valid_d       = hit_d;
        if (charge_exit_d) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (!hit_d[i]) begin
                    cap_d[i] = TIMEOUT_C;
                end
            end
            valid_d = '1;
        end
    end

    // Scan sequencer: IDLE -> DISCHARGE -> CHARGE -> EVAL, aborting to IDLE when enable drops mid-scan.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dis_cnt_q <= '0;
            cnt_q     <= '0;
            drive_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    drive_q <= 1'b0;
                    if (enable) begin
                        state_q   <= S_DISCHARGE;
                        dis_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_DISCHARGE: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        drive_q <= 1'b0;
                    end else if (dis_cnt_q == DIS_LAST_C) begin
                        state_q <= S_CHARGE;
                        cnt_q   <= '0;
                        valid_q <= '0;
                        drive_q <= 1'b1;
                    end else begin
                        dis_cnt_q <= dis_cnt_q + 1'b1;
                    end
                end
                S_CHARGE: begin
                    if (!enable) begin
                        // Partial scan is dropped: captures never reach EVAL.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        drive_q <= 1'b0;
                    end else begin
                        valid_q <= valid_d;
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            cap_q[i] <= cap_d[i];
                        end
                        if (charge_exit_d) begin
                            state_q <= S_EVAL;
                            drive_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // Exit happens at TIMEOUT, so the counter cannot wrap.
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    drive_q <= 1'b0;
                    if (enable) begin
                        state_q   <= S_DISCHARGE;
                        dis_cnt_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    // Threshold each capture and run the per-channel agree counters; only EVAL advances them.
    always_comb begin
        touched_d = touched_q;
        raw_d     = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            raw_d[i]    = (cap_q[i] > THRESHOLD_C);
            db_cnt_d[i] = db_cnt_q[i];
            if (state_q == S_EVAL) begin
                if (raw_d[i] == touched_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if ((db_cnt_q[i] + 1'b1) == DB_LAST_C) begin
                    touched_d[i] = raw_d[i];
                    db_cnt_d[i]  = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Rising touched edges latch a press; a simultaneous clear loses to the set.
    always_comb begin
        press_d = (press_q & ~clear_mask) | (touched_q & ~touched_prev_q);
    end

    // Debounced state, edge-detect history and press latches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            touched_q      <= '0;
            touched_prev_q <= '0;
            press_q        <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            touched_q      <= touched_d;
            touched_prev_q <= touched_q;
            press_q        <= press_d;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign capacitive_sensors_out = drive_q;
    assign touched                = touched_q;
    assign press_pending          = press_q;
    assign scan_done              = done_q;
    assign busy                   = busy_q;

endmodule

// File: tb/tb_cap_sensor_scanner.sv
// Directed bench for cap_sensor_scanner: scan timing, capture-derived scan length, debounce, press latching, abort and reset.
// Expected values are hand-computed from the default parameters (9 channels, threshold 50, discharge 8, timeout 255, debounce 3).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_cap_sensor_scanner;

    localparam int DIS = 8;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [8:0] sens;
    logic       capacitive_sensors_out;
    logic [8:0] touched;
    logic [8:0] press_pending;
    logic [8:0] clear_mask;
    logic       scan_done;
    logic       busy;

    int total;
    int bad;
    int cyc;
    int done_cnt;
    int mark_cyc;
    int saved_done;
    int rise_at [9];
    bit ok;

    cap_sensor_scanner dut (
        .clock                  (clock),
        .reset                  (reset),
        .enable                 (enable),
        .capacitive_sensors_in  (sens),
        .capacitive_sensors_out (capacitive_sensors_out),
        .touched                (touched),
        .press_pending          (press_pending),
        .clear_mask             (clear_mask),
        .scan_done              (scan_done),
        .busy                   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (scan_done === 1'b1) done_cnt++;
    endtask

    task automatic set_rise(input int all, input int ch, input int ch_at);
        for (int i = 0; i < 9; i++) rise_at[i] = all;
        rise_at[ch] = ch_at;
    endtask

    task automatic wait_charge();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!seen) begin
                step();
                if (capacitive_sensors_out === 1'b1) seen = 1'b1;
            end
        end
        chk("charge_entry", 32'(seen), 32'd1);
    endtask

    // One full scan from the IDLE/EVAL sample point up to the next EVAL sample point.
    task automatic do_scan(input int exp_charge);
        int  d0;
        int  k;
        bit  in_charge;
        d0 = done_cnt;
        wait_charge();
        chk("discharge_len", 32'(cyc - mark_cyc - 1), 32'(DIS));
        k = 0;
        in_charge = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (in_charge) begin
                if (capacitive_sensors_out === 1'b1) begin
                    for (int i = 0; i < 9; i++) if (rise_at[i] == k) sens[i] = 1'b1;
                    k++;
                    step();
                end else begin
                    in_charge = 1'b0;
                end
            end
        end
        chk("charge_len", 32'(k), 32'(exp_charge));
        chk("scan_done_in_eval", 32'(scan_done), 32'd1);
        chk("single_pulse", 32'(done_cnt - d0), 32'd1);
        chk("busy_in_eval", 32'(busy), 32'd1);
        sens = '0;
        mark_cyc = cyc;
    endtask

    task automatic after_eval(input logic [8:0] exp_touched);
        step();
        chk("touched", 32'(touched), 32'(exp_touched));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; done_cnt = 0; mark_cyc = 0;
        reset = 1'b1; enable = 1'b0; sens = '0; clear_mask = '0;
        for (int i = 0; i < 9; i++) rise_at[i] = -1;

        // Reset state.
        step(); step(); step();
        chk("rst_out", 32'(capacitive_sensors_out), 32'd0);
        chk("rst_touched", 32'(touched), 32'd0);
        chk("rst_press", 32'(press_pending), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Released but disabled: stays idle.
        reset = 1'b0;
        step(); step(); step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done_cnt", 32'(done_cnt), 32'd0);

        // All channels rise 10 clocks into CHARGE: capture 12, 13 charge cycles, never touched.
        enable = 1'b1;
        mark_cyc = cyc;
        set_rise(10, 0, 10);
        for (int s = 0; s < 3; s++) begin
            do_scan(13);
            chk("early_period", 32'(cyc - (mark_cyc - 22)), 32'd22);
            after_eval(9'h000);
        end

        // Channel 4 captures 80 for three scans: touched after the third, press one cycle later.
        set_rise(10, 4, 78);
        do_scan(81);
        after_eval(9'h000);
        do_scan(81);
        after_eval(9'h000);
        do_scan(81);
        after_eval(9'h010);
        chk("press_not_yet", 32'(press_pending), 32'd0);
        clear_mask = 9'h010;
        step();
        chk("press_set_beats_clear", 32'(press_pending), 32'h010);
        step();
        chk("press_cleared", 32'(press_pending), 32'd0);
        clear_mask = '0;

        // Channel 0 never rises: timeout capture, 256 charge cycles, touched after three scans.
        set_rise(10, 0, -1);
        rise_at[4] = 78;
        do_scan(256);
        after_eval(9'h010);
        do_scan(256);
        after_eval(9'h010);
        do_scan(256);
        after_eval(9'h011);
        chk("press0_not_yet", 32'(press_pending), 32'd0);
        step();
        chk("press0_set", 32'(press_pending), 32'h001);

        // Channel 2 alternates every scan: debounce never lets it through.
        for (int s = 0; s < 4; s++) begin
            rise_at[2] = (s % 2 == 0) ? 78 : 10;
            do_scan(256);
            after_eval(9'h011);
        end
        chk("press_after_alt", 32'(press_pending), 32'h001);

        // Enable dropped mid-CHARGE: abort to IDLE, no pulse, state kept.
        sens = '0;
        wait_charge();
        for (int n = 0; n < 20; n++) step();
        chk("still_charging", 32'(capacitive_sensors_out), 32'd1);
        saved_done = done_cnt;
        enable = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out", 32'(capacitive_sensors_out), 32'd0);
        chk("abort_done", 32'(scan_done), 32'd0);
        for (int n = 0; n < 30; n++) step();
        chk("abort_no_pulse", 32'(done_cnt - saved_done), 32'd0);
        chk("abort_touched", 32'(touched), 32'h011);
        chk("abort_press", 32'(press_pending), 32'h001);
        chk("abort_idle", 32'(busy), 32'd0);

        // Reset mid-CHARGE: immediate return to IDLE with state cleared.
        enable = 1'b1;
        wait_charge();
        for (int n = 0; n < 5; n++) step();
        saved_done = done_cnt;
        reset = 1'b1;
        #1;
        chk("rrst_out", 32'(capacitive_sensors_out), 32'd0);
        chk("rrst_busy", 32'(busy), 32'd0);
        chk("rrst_touched", 32'(touched), 32'd0);
        chk("rrst_press", 32'(press_pending), 32'd0);
        chk("rrst_done", 32'(scan_done), 32'd0);
        step(); step();
        reset = 1'b0;
        enable = 1'b0;
        for (int n = 0; n < 5; n++) step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_no_pulse", 32'(done_cnt - saved_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
